// File: rtl/rst_sync_pkg.sv
// -----------------------------------------------------------------------------
// rst_sync_pkg
//   Shared constants and helpers for the reset synchronizer.
//   - NUM_STAGES_MIN / NUM_STAGES_MAX : legal synchronizer depth range
//   - HOLD_CYCLES_MIN / HOLD_CYCLES_MAX : legal stretch hold range
//   - cnt_width() : bit width needed to hold the value HOLD_CYCLES
// -----------------------------------------------------------------------------
package rst_sync_pkg;

  localparam int NUM_STAGES_MIN  = 2;
  localparam int NUM_STAGES_MAX  = 8;
  localparam int HOLD_CYCLES_MIN = 1;
  localparam int HOLD_CYCLES_MAX = 255;

  // Width of a down-counter that must be able to hold hold_cycles itself.
  function automatic int cnt_width(input int hold_cycles);
    return $clog2(hold_cycles + 1);
  endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// -----------------------------------------------------------------------------
// rst_sync_chain
//   Preset flop chain for reset synchronization. All stages are set to 1
//   asynchronously by RST; once RST is low a 0 enters stage 0 and walks one
//   stage per rising CLK edge.
//
// Ports:
//   CLK         in   domain clock, rising edge
//   RST         in   asynchronous active-high reset (presets the chain)
//   last_stage  out  last flop of the chain (the synchronized release level)
//   next_last   out  flop feeding the last stage (value last_stage takes next)
// -----------------------------------------------------------------------------
module rst_sync_chain
  import rst_sync_pkg::*;
#(
  parameter int STAGES = 3
) (
  input  logic CLK,
  input  logic RST,
  output logic last_stage,
  output logic next_last
);

  logic [STAGES-1:0] stages_r;

  // Shift register: preset to all ones by RST, shifts in zeros afterwards.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stages_r <= {STAGES{1'b1}};
    end else begin
      stages_r <= {stages_r[STAGES-2:0], 1'b0};
    end
  end

  assign last_stage = stages_r[STAGES-1];
  assign next_last  = stages_r[STAGES-2];

endmodule

// File: rtl/rst_sync.sv
// -----------------------------------------------------------------------------
// rst_sync
//   Reset synchronizer for one clock domain. SYNC_RST asserts immediately
//   with RST and deasserts synchronously NUM_STAGES rising edges after RST
//   falls. RST_RELEASED pulses for the single cycle after SYNC_RST falls.
//
//   Optional feature macro: RST_SYNC_STRETCH_EN
//     defined   -> SYNC_RST held HOLD_CYCLES further edges after the chain
//                  releases (total NUM_STAGES + HOLD_CYCLES edges)
//     undefined -> SYNC_RST is the last chain flop, HOLD_CYCLES unused
//
// Ports:
//   CLK           in   domain clock, rising edge
//   RST           in   asynchronous active-high reset source
//   SYNC_RST      out  synchronized reset, active high, driven by a flop
//   RST_RELEASED  out  one-cycle pulse following SYNC_RST deassertion
// -----------------------------------------------------------------------------
module rst_sync
  import rst_sync_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST,
  output logic SYNC_RST,
  output logic RST_RELEASED
);

  // Elaboration-time parameter range checks.
  if (NUM_STAGES < NUM_STAGES_MIN || NUM_STAGES > NUM_STAGES_MAX) begin : g_bad_stages
    $error("rst_sync: NUM_STAGES=%0d outside legal range %0d..%0d",
           NUM_STAGES, NUM_STAGES_MIN, NUM_STAGES_MAX);
  end
  if (HOLD_CYCLES < HOLD_CYCLES_MIN || HOLD_CYCLES > HOLD_CYCLES_MAX) begin : g_bad_hold
    $error("rst_sync: HOLD_CYCLES=%0d outside legal range %0d..%0d",
           HOLD_CYCLES, HOLD_CYCLES_MIN, HOLD_CYCLES_MAX);
  end

  logic chain_out_s;     // last chain flop
  logic chain_pre_s;     // value the last chain flop takes at the next edge
  logic sync_next_s;     // value SYNC_RST takes at the next edge
  logic rst_released_r;

  rst_sync_chain #(
    .STAGES(NUM_STAGES)
  ) u_chain (
    .CLK        (CLK),
    .RST        (RST),
    .last_stage (chain_out_s),
    .next_last  (chain_pre_s)
  );

`ifdef RST_SYNC_STRETCH_EN
  localparam int               CNT_W     = cnt_width(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  logic [CNT_W-1:0] hold_cnt_r;
  logic             sync_rst_r;
  logic             unused_chain_pre_s;

  // The look-ahead tap is only needed when SYNC_RST is the chain itself.
  assign unused_chain_pre_s = chain_pre_s;

  // Next SYNC_RST: the output falls on the edge that takes the counter 1 -> 0.
  always_comb begin
    sync_next_s = 1'b1;
    if (chain_out_s) begin
      sync_next_s = 1'b1;
    end else if (hold_cnt_r > CNT_ONE) begin
      sync_next_s = 1'b1;
    end else begin
      sync_next_s = 1'b0;
    end
  end

  // Hold counter and output flop; counting starts once the chain has released.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_cnt_r <= HOLD_LOAD;
      sync_rst_r <= 1'b1;
    end else begin
      sync_rst_r <= sync_next_s;
      if (!chain_out_s && hold_cnt_r != CNT_ZERO) begin
        hold_cnt_r <= hold_cnt_r - CNT_ONE;
      end
    end
  end

  assign SYNC_RST = sync_rst_r;
`else
  // Without stretch the last chain flop is the output, so its next value is
  // simply the stage behind it.
  assign sync_next_s = chain_pre_s;
  assign SYNC_RST    = chain_out_s;
`endif

  // Release pulse: set on the edge where SYNC_RST goes from 1 to 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rst_released_r <= 1'b0;
    end else begin
      rst_released_r <= SYNC_RST & ~sync_next_s;
    end
  end

  assign RST_RELEASED = rst_released_r;

endmodule

// File: tb/tb_rst_sync.sv
// -----------------------------------------------------------------------------
// tb_rst_sync
//   Self-checking bench for rst_sync. Three instances (NUM_STAGES 2, 3, 8)
//   share one clock and reset. The reference model counts rising edges seen
//   since RST was last high; each instance must show SYNC_RST=1 while that
//   count is below its release latency and RST_RELEASED=1 exactly when the
//   count equals the latency.
// -----------------------------------------------------------------------------
module tb_rst_sync;

`ifdef RST_SYNC_STRETCH_EN
  localparam int H = 4;
`else
  localparam int H = 0;
`endif
  localparam int L2 = 2 + H;
  localparam int L3 = 3 + H;
  localparam int L8 = 8 + H;

  logic CLK = 1'b0;
  logic RST;
  logic sync2, rel2, sync3, rel3, sync8, rel8;

  int tests  = 0;
  int failed = 0;
  int m_edges = 0;
  logic [5:0] obs;
  logic [5:0] expv;

  rst_sync #(.NUM_STAGES(2), .HOLD_CYCLES(4)) u_dut2 (
    .CLK(CLK), .RST(RST), .SYNC_RST(sync2), .RST_RELEASED(rel2));
  rst_sync #(.NUM_STAGES(3), .HOLD_CYCLES(4)) u_dut3 (
    .CLK(CLK), .RST(RST), .SYNC_RST(sync3), .RST_RELEASED(rel3));
  rst_sync #(.NUM_STAGES(8), .HOLD_CYCLES(4)) u_dut8 (
    .CLK(CLK), .RST(RST), .SYNC_RST(sync8), .RST_RELEASED(rel8));

  always #50 CLK = ~CLK;

  // Reference model: edges counted since reset was last high.
  always @(posedge CLK or posedge RST) begin
    if (RST) m_edges <= 0;
    else if (m_edges < 1000) m_edges <= m_edges + 1;
  end

  function automatic logic [5:0] exp_vec();
    return {m_edges < L2, m_edges == L2,
            m_edges < L3, m_edges == L3,
            m_edges < L8, m_edges == L8};
  endfunction

  // Advance to 20 time units after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #20;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    #1;
    obs = {sync2, rel2, sync3, rel3, sync8, rel8};
    tests++;
    if (obs !== 6'b101010) begin
      failed++;
      $display("FAIL reset_async_t0: got %b expected %b", obs, 6'b101010);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      obs = {sync2, rel2, sync3, rel3, sync8, rel8};
      tests++;
      if (obs !== 6'b101010) begin
        failed++;
        $display("FAIL reset_held cycle %0d: got %b expected %b", i, obs, 6'b101010);
      end
    end
  endtask

  task automatic test_release();
    #10 RST = 1'b0;
    for (int i = 0; i < L8 + 4; i++) begin
      tick();
      obs = {sync2, rel2, sync3, rel3, sync8, rel8};
      expv = exp_vec();
      tests++;
      if (obs !== expv) begin
        failed++;
        $display("FAIL release edge %0d: got %b expected %b", i + 1, obs, expv);
      end
    end
  endtask

  task automatic test_async_assert();
    #30 RST = 1'b1;  // mid-cycle, no clock edge follows for 50 units
    #1;
    obs = {sync2, rel2, sync3, rel3, sync8, rel8};
    tests++;
    if (obs !== 6'b101010) begin
      failed++;
      $display("FAIL async_assert: got %b expected %b", obs, 6'b101010);
    end
    tick();
    #10 RST = 1'b0;
    for (int i = 0; i < L8 + 3; i++) begin
      tick();
      obs = {sync2, rel2, sync3, rel3, sync8, rel8};
      expv = exp_vec();
      tests++;
      if (obs !== expv) begin
        failed++;
        $display("FAIL async_then_release edge %0d: got %b expected %b", i + 1, obs, expv);
      end
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    #10 RST = 1'b1;
    #1;
    obs = {sync2, rel2, sync3, rel3, sync8, rel8};
    tests++;
    if (obs !== 6'b101010) begin
      failed++;
      $display("FAIL glitch_assert: got %b expected %b", obs, 6'b101010);
    end
    #9 RST = 1'b0;  // 10-unit pulse, entirely between edges
    for (int i = 0; i < L8 + 3; i++) begin
      tick();
      obs = {sync2, rel2, sync3, rel3, sync8, rel8};
      expv = exp_vec();
      pulses += int'(rel3);
      tests++;
      if (obs !== expv) begin
        failed++;
        $display("FAIL glitch edge %0d: got %b expected %b", i + 1, obs, expv);
      end
    end
    tests++;
    if (pulses !== 1) begin
      failed++;
      $display("FAIL glitch_pulse_count: got %0d expected %0d", pulses, 1);
    end
  endtask

  task automatic test_mid_countdown();
    int pulses = 0;
    #10 RST = 1'b1;
    tick();
    #10 RST = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      obs = {sync2, rel2, sync3, rel3, sync8, rel8};
      expv = exp_vec();
      pulses += int'(rel3);
      tests++;
      if (obs !== expv) begin
        failed++;
        $display("FAIL midcount_first edge %0d: got %b expected %b", i + 1, obs, expv);
      end
    end
    #10 RST = 1'b1;
    tick();
    #10 RST = 1'b0;
    for (int i = 0; i < L8 + 3; i++) begin
      tick();
      obs = {sync2, rel2, sync3, rel3, sync8, rel8};
      expv = exp_vec();
      pulses += int'(rel3);
      tests++;
      if (obs !== expv) begin
        failed++;
        $display("FAIL midcount_final edge %0d: got %b expected %b", i + 1, obs, expv);
      end
    end
    tests++;
    if (pulses !== 1) begin
      failed++;
      $display("FAIL midcount_pulse_count: got %0d expected %0d", pulses, 1);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int hi_cycles = int'($urandom_range(0, 3));
      int lo_cycles = int'($urandom_range(0, L8 + 3));
      #10 RST = 1'b1;
      if (hi_cycles == 0) begin
        #($urandom_range(1, 40)) RST = 1'b0;  // sub-cycle glitch
      end else begin
        for (int k = 0; k < hi_cycles; k++) tick();
        #10 RST = 1'b0;
      end
      for (int k = 0; k <= lo_cycles; k++) begin
        tick();
        obs = {sync2, rel2, sync3, rel3, sync8, rel8};
        expv = exp_vec();
        tests++;
        if (obs !== expv) begin
          failed++;
          $display("FAIL random iter %0d edge %0d: got %b expected %b", it, k + 1, obs, expv);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_async_assert();
    test_glitch();
    test_mid_countdown();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
